// File: rtl/mp_icache_ctrl_unit.sv
// Register-mapped control unit for the multi-port instruction cache.
// A peripheral slave port exposes enable/bypass, full flush, selective flush,
// status and statistics registers. Operations that need the cache banks to
// handshake park the FSM in a WAIT state until the acknowledge arrives. The
// slave port answers every accepted request with exactly one response beat.
module mp_icache_ctrl_unit #(
    parameter int NB_CORES = 8,
    parameter int ID_WIDTH = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                speriph_req_i,
    input  logic [31:0]         speriph_add_i,
    input  logic                speriph_wen_i,
    input  logic [31:0]         speriph_wdata_i,
    input  logic [3:0]          speriph_be_i,
    input  logic [ID_WIDTH-1:0] speriph_id_i,

    output logic                speriph_gnt_o,
    output logic                speriph_r_valid_o,
    output logic [31:0]         speriph_r_rdata_o,
    output logic                speriph_r_opc_o,
    output logic [ID_WIDTH-1:0] speriph_r_id_o,

    output logic                bypass_req_o,
    input  logic [NB_CORES:0]   bypass_ack_i,
    output logic                flush_req_o,
    input  logic                flush_ack_i,

    output logic                sel_flush_req_o,
    output logic [31:0]         sel_flush_addr_o,
    input  logic                sel_flush_ack_i,

    input  logic [31:0]         global_hit_count_i,
    input  logic [31:0]         global_trans_count_i,
    input  logic [31:0]         global_miss_count_i,
    input  logic [31:0]         global_cong_count_i,
    output logic                ctrl_clear_regs_o,
    output logic                ctrl_enable_regs_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYPASS,
        S_WAIT_FLUSH,
        S_WAIT_SEL_FLUSH,
        S_RESP
    } state_t;

    typedef enum logic [3:0] {
        R_ENABLE,
        R_FLUSH,
        R_SEL_FLUSH,
        R_STATUS,
        R_STAT_CTRL,
        R_HIT,
        R_TRANS,
        R_MISS,
        R_CONG,
        R_NONE
    } reg_sel_t;

    state_t   state;
    state_t   state_next;
    reg_sel_t reg_sel;
    logic     is_write;
    logic     busy;
    logic     bypass_done;
    logic     grant;
    logic [31:0] rd_data;

    // Byte enables are meaningless here (all writes are full-word) and only
    // address bits [5:2] select a register; fold the rest into a dead net.
    logic unused_bits;
    assign unused_bits = ^{speriph_be_i, speriph_add_i[31:6], speriph_add_i[1:0]};

    assign is_write    = ~speriph_wen_i;
    assign busy        = (state != S_IDLE);
    assign bypass_done = (bypass_ack_i == {(NB_CORES+1){bypass_req_o}});
    assign grant       = speriph_gnt_o;

    // Decode the register offset; bit 5 only opens up the congestion counter.
    always_comb begin
        reg_sel = R_NONE;
        if (!speriph_add_i[5]) begin
            case (speriph_add_i[4:2])
                3'd0:    reg_sel = R_ENABLE;
                3'd1:    reg_sel = R_FLUSH;
                3'd2:    reg_sel = R_SEL_FLUSH;
                3'd3:    reg_sel = R_STATUS;
                3'd4:    reg_sel = R_STAT_CTRL;
                3'd5:    reg_sel = R_HIT;
                3'd6:    reg_sel = R_TRANS;
                default: reg_sel = R_MISS;
            endcase
        end else if (speriph_add_i[4:2] == 3'd0) begin
            reg_sel = R_CONG;
        end
    end

    // Read data mux; counters are captured in the grant cycle by the response register.
    always_comb begin
        rd_data = 32'b0;
        case (reg_sel)
            R_ENABLE:    rd_data = {31'b0, ~bypass_req_o};
            R_FLUSH:     rd_data = 32'b0;
            R_SEL_FLUSH: rd_data = sel_flush_addr_o;
            R_STATUS:    rd_data = {30'b0, busy, &bypass_ack_i};
            R_STAT_CTRL: rd_data = {31'b0, ctrl_enable_regs_o};
            R_HIT:       rd_data = global_hit_count_i;
            R_TRANS:     rd_data = global_trans_count_i;
            R_MISS:      rd_data = global_miss_count_i;
            R_CONG:      rd_data = global_cong_count_i;
            default:     rd_data = 32'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and grant; requests are only accepted while idle.
    always_comb begin
        state_next    = state;
        speriph_gnt_o = 1'b0;
        case (state)
            S_IDLE: begin
                speriph_gnt_o = speriph_req_i;
                if (speriph_req_i) begin
                    if (is_write && reg_sel == R_ENABLE) begin
                        state_next = S_WAIT_BYPASS;
                    end else if (is_write && reg_sel == R_FLUSH) begin
                        state_next = S_WAIT_FLUSH;
                    end else if (is_write && reg_sel == R_SEL_FLUSH) begin
                        state_next = S_WAIT_SEL_FLUSH;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_WAIT_BYPASS: begin
                if (bypass_done) begin
                    state_next = S_RESP;
                end
            end
            S_WAIT_FLUSH: begin
                if (flush_ack_i) begin
                    state_next = S_RESP;
                end
            end
            S_WAIT_SEL_FLUSH: begin
                if (sel_flush_ack_i) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The response beat is simply the RESP state; its payload is held below.
    assign speriph_r_valid_o = (state == S_RESP);

    // Response payload, captured at grant and held until the next grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            speriph_r_rdata_o <= 32'b0;
            speriph_r_opc_o   <= 1'b0;
            speriph_r_id_o    <= '0;
        end else if (grant) begin
            speriph_r_rdata_o <= is_write ? 32'b0 : rd_data;
            speriph_r_opc_o   <= (reg_sel == R_NONE);
            speriph_r_id_o    <= speriph_id_i;
        end
    end

    // Cache control outputs: requests stay high until their ack is sampled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bypass_req_o       <= 1'b1;
            flush_req_o        <= 1'b0;
            sel_flush_req_o    <= 1'b0;
            sel_flush_addr_o   <= 32'b0;
            ctrl_enable_regs_o <= 1'b0;
            ctrl_clear_regs_o  <= 1'b0;
        end else begin
            ctrl_clear_regs_o <= 1'b0;
            if (grant && is_write) begin
                case (reg_sel)
                    R_ENABLE: begin
                        bypass_req_o <= ~speriph_wdata_i[0];
                    end
                    R_FLUSH: begin
                        flush_req_o <= 1'b1;
                    end
                    R_SEL_FLUSH: begin
                        sel_flush_addr_o <= speriph_wdata_i;
                        sel_flush_req_o  <= 1'b1;
                    end
                    R_STAT_CTRL: begin
                        ctrl_enable_regs_o <= speriph_wdata_i[0];
                        ctrl_clear_regs_o  <= speriph_wdata_i[1];
                    end
                    default: begin
                    end
                endcase
            end
            if (state == S_WAIT_FLUSH && flush_ack_i) begin
                flush_req_o <= 1'b0;
            end
            if (state == S_WAIT_SEL_FLUSH && sel_flush_ack_i) begin
                sel_flush_req_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mp_icache_ctrl_unit.sv
// Self-checking bench for mp_icache_ctrl_unit: directed scenarios followed by
// randomized register traffic against a transaction-level reference model.
module tb_mp_icache_ctrl_unit;

    localparam int NB_CORES = 8;
    localparam int ID_WIDTH = 5;
    localparam int AW       = NB_CORES + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req = 1'b0;
    logic [31:0]         add = '0;
    logic                wen = 1'b1;
    logic [31:0]         wdata = '0;
    logic [3:0]          be = '0;
    logic [ID_WIDTH-1:0] id = '0;
    logic                gnt;
    logic                r_valid;
    logic [31:0]         r_rdata;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic                bypass_req;
    logic [AW-1:0]       bypass_ack = '1;
    logic                flush_req;
    logic                flush_ack = 1'b0;
    logic                sel_req;
    logic [31:0]         sel_addr;
    logic                sel_ack = 1'b0;
    logic [31:0]         hit_cnt = '0;
    logic [31:0]         trans_cnt = '0;
    logic [31:0]         miss_cnt = '0;
    logic [31:0]         cong_cnt = '0;
    logic                clear_regs;
    logic                enable_regs;

    always #5 clk = ~clk;

    mp_icache_ctrl_unit #(.NB_CORES(NB_CORES), .ID_WIDTH(ID_WIDTH)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .speriph_req_i        (req),
        .speriph_add_i        (add),
        .speriph_wen_i        (wen),
        .speriph_wdata_i      (wdata),
        .speriph_be_i         (be),
        .speriph_id_i         (id),
        .speriph_gnt_o        (gnt),
        .speriph_r_valid_o    (r_valid),
        .speriph_r_rdata_o    (r_rdata),
        .speriph_r_opc_o      (r_opc),
        .speriph_r_id_o       (r_id),
        .bypass_req_o         (bypass_req),
        .bypass_ack_i         (bypass_ack),
        .flush_req_o          (flush_req),
        .flush_ack_i          (flush_ack),
        .sel_flush_req_o      (sel_req),
        .sel_flush_addr_o     (sel_addr),
        .sel_flush_ack_i      (sel_ack),
        .global_hit_count_i   (hit_cnt),
        .global_trans_count_i (trans_cnt),
        .global_miss_count_i  (miss_cnt),
        .global_cong_count_i  (cong_cnt),
        .ctrl_clear_regs_o    (clear_regs),
        .ctrl_enable_regs_o   (enable_regs)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the architecturally visible register state.
    bit          m_bypass = 1'b1;
    bit          m_enable = 1'b0;
    logic [31:0] m_sel    = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bypass = 1'b1;
        m_enable = 1'b0;
        m_sel    = '0;
    endtask

    // One complete register access. Called at posedge+1 with the unit idle.
    // wait_cyc: cycles the cache withholds its acknowledge; old_ack: during
    // the bypass wait, keep acks at the previous level instead of random junk.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int wait_cyc, input bit old_ack);
        logic [3:0]          off;
        bit                  mapped;
        int                  kind;   // 0 direct, 1 bypass, 2 flush, 3 sel flush
        bit                  chk_rd;
        bit                  exp_clr;
        logic [31:0]         exp_rd;
        logic [ID_WIDTH-1:0] tid;
        logic [AW-1:0]       match;
        off     = addr[5:2];
        mapped  = (off[3] == 1'b0) || (off == 4'd8);
        kind    = 0;
        chk_rd  = !wr;
        exp_clr = 1'b0;
        exp_rd  = 32'b0;
        tid     = ID_WIDTH'($urandom);
        if (mapped) begin
            case (off)
                4'd0: if (wr) kind = 1; else exp_rd = {31'b0, ~m_bypass};
                4'd1: if (wr) kind = 2; else chk_rd = 1'b0;
                4'd2: if (wr) kind = 3; else chk_rd = 1'b0;
                4'd3: exp_rd = {31'b0, &bypass_ack};
                4'd4: begin
                    if (wr) begin
                        m_enable = wd[0];
                        exp_clr  = wd[1];
                    end else begin
                        exp_rd = {31'b0, m_enable};
                    end
                end
                4'd5: exp_rd = hit_cnt;
                4'd6: exp_rd = trans_cnt;
                4'd7: exp_rd = miss_cnt;
                default: exp_rd = cong_cnt;
            endcase
        end
        req   = 1'b1;
        add   = addr;
        wen   = !wr;
        wdata = wd;
        be    = 4'($urandom);
        id    = tid;
        #1;
        chk("gnt_idle", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        hit_cnt   = $urandom;
        trans_cnt = $urandom;
        miss_cnt  = $urandom;
        cong_cnt  = $urandom;
        if (kind == 1) m_bypass = ~wd[0];
        if (kind == 3) m_sel = wd;
        if (kind != 0) begin
            match = {AW{m_bypass}};
            for (int c = 0; c <= wait_cyc; c++) begin
                if (kind == 1) begin
                    if (c == wait_cyc) bypass_ack = match;
                    else if (old_ack) bypass_ack = ~match;
                    else begin
                        bypass_ack = AW'($urandom);
                        if (bypass_ack == match) bypass_ack[0] = ~bypass_ack[0];
                    end
                end
                flush_ack = (kind == 2) && (c == wait_cyc);
                sel_ack   = (kind == 3) && (c == wait_cyc);
                chk("wait_valid", 32'(r_valid), 32'd0);
                chk("wait_gnt", 32'(gnt), 32'd0);
                chk("wait_bypass_req", 32'(bypass_req), 32'(m_bypass));
                chk("wait_flush_req", 32'(flush_req), 32'(kind == 2));
                chk("wait_sel_req", 32'(sel_req), 32'(kind == 3));
                if (kind == 3) chk("wait_sel_addr", sel_addr, m_sel);
                @(posedge clk); #1;
                flush_ack = 1'b0;
                sel_ack   = 1'b0;
            end
        end
        chk("resp_valid", 32'(r_valid), 32'd1);
        chk("resp_gnt", 32'(gnt), 32'd0);
        chk("resp_opc", 32'(r_opc), 32'(!mapped));
        chk("resp_id", 32'(r_id), 32'(tid));
        if (chk_rd) chk("resp_rdata", r_rdata, exp_rd);
        chk("clear_pulse", 32'(clear_regs), 32'(exp_clr));
        chk("enable_regs", 32'(enable_regs), 32'(m_enable));
        chk("bypass_req", 32'(bypass_req), 32'(m_bypass));
        chk("flush_req_done", 32'(flush_req), 32'd0);
        chk("sel_req_done", 32'(sel_req), 32'd0);
        chk("sel_addr", sel_addr, m_sel);
        req = 1'b0;
        @(posedge clk); #1;
        chk("resp_single", 32'(r_valid), 32'd0);
        chk("clear_after", 32'(clear_regs), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(r_valid), 32'd0);
        chk("rst_bypass", 32'(bypass_req), 32'd1);
        chk("rst_flush", 32'(flush_req), 32'd0);
        chk("rst_sel", 32'(sel_req), 32'd0);
        chk("rst_sel_addr", sel_addr, 32'd0);
        chk("rst_enable", 32'(enable_regs), 32'd0);
        chk("rst_clear", 32'(clear_regs), 32'd0);
        chk("rst_rdata", r_rdata, 32'd0);
        chk("rst_opc", 32'(r_opc), 32'd0);
        chk("rst_id", 32'(r_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Enable the cache: acks linger at all-1 for 5 cycles, then all-0
        access(1'b1, 32'h0000_0000, 32'h1, 5, 1'b1);
        // Full flush with ack in the fourth wait cycle
        access(1'b1, 32'h0000_0004, 32'h0, 3, 1'b0);
        // Selective flush
        access(1'b1, 32'h0000_0008, 32'h1C00_0040, 2, 1'b0);
        // Stats control: enable and clear, then hit counter read
        access(1'b1, 32'h0000_0010, 32'h3, 0, 1'b0);
        hit_cnt = 32'h0000_1234;
        access(1'b0, 32'h0000_0014, 32'h0, 0, 1'b0);
        // Unmapped offset 0x24
        access(1'b0, 32'h0000_0024, 32'h0, 0, 1'b0);
        // ENABLE and STATUS readback
        access(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0);
        access(1'b0, 32'h0000_000C, 32'h0, 0, 1'b0);

        // Reset in the middle of a flush wait
        req = 1'b1; add = 32'h0000_0004; wen = 1'b0; wdata = 32'h0; id = 5'd7;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_flush_pending", 32'(flush_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_flush", 32'(flush_req), 32'd0);
        chk("midrst_bypass", 32'(bypass_req), 32'd1);
        chk("midrst_valid", 32'(r_valid), 32'd0);
        chk("midrst_enable", 32'(enable_regs), 32'd0);
        model_reset();
        bypass_ack = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("postrst_valid", 32'(r_valid), 32'd0);
            chk("postrst_flush", 32'(flush_req), 32'd0);
        end

        // Randomized register traffic
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a         = $urandom;
            a[5:2]    = 4'($urandom_range(0, 15));
            hit_cnt   = $urandom;
            trans_cnt = $urandom;
            miss_cnt  = $urandom;
            cong_cnt  = $urandom;
            if ($urandom_range(0, 3) == 0) bypass_ack = AW'($urandom);
            access(1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
